// File: rtl/fsub_seq_pkg.sv
// Shared types and constants for the sequential single-precision subtractor.
// Holds the FSM state encoding, the unpacked operand struct and an unpack helper.
package fsub_seq_pkg;

    localparam int          EXP_W   = 8;
    localparam int          MAN_W   = 23;
    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN    = 32'h7FC00000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPECIAL,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } fsub_state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [26:0]      man;   // {hidden, fraction, guard, round, sticky}
    } fp_unpacked_t;

    // Subnormals get exponent 1 and no hidden bit so they line up with the smallest normals.
    function automatic fp_unpacked_t unpack_fp(input logic [31:0] x);
        fp_unpacked_t u;
        u.sign = x[31];
        u.exp  = (x[30:MAN_W] == '0) ? 8'd1 : x[30:MAN_W];
        u.man  = {|x[30:MAN_W], x[MAN_W-1:0], 3'b000};
        return u;
    endfunction

endpackage

// File: rtl/fsub_seq_special.sv
// Purpose: NaN/Inf result for a - b, given a and b with its sign already inverted.
// Latency: combinational. Backpressure: none, sampled by the parent in its SPECIAL state.
module fsub_seq_special
    import fsub_seq_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res
);

    logic a_max, b_max, a_nan, b_nan, a_inf, b_inf;

    always_comb begin
        a_max = (a[30:23] == EXP_MAX);
        b_max = (b[30:23] == EXP_MAX);
        a_nan = a_max && (a[22:0] != '0);
        b_nan = b_max && (b[22:0] != '0);
        a_inf = a_max && (a[22:0] == '0);
        b_inf = b_max && (b[22:0] == '0);

        res = '0;
        if (a_nan && b_nan) begin
            if (a[31] == b[31])
                res = {b[31], 9'h1FF, b[21:0]};
            else
                res = {10'h1FF, b[21:0]};
        end else if (b_nan) begin
            res = {b[31], 9'h1FF, b[21:0]};
        end else if (a_nan) begin
            res = {a[31], 9'h1FF, a[21:0]};
        end else if (a_inf && b_inf) begin
            // Opposite effective signs means Inf - Inf of like signs: invalid.
            res = (a[31] != b[31]) ? QNAN : {a[31], EXP_MAX, 23'b0};
        end else if (a_inf) begin
            res = {a[31], EXP_MAX, 23'b0};
        end else if (b_inf) begin
            res = {b[31], EXP_MAX, 23'b0};
        end
    end

endmodule

// File: rtl/fsub_seq.sv
// Purpose: iterative IEEE single subtractor res = a - b, round-to-nearest-even.
// Latency: 2 cycles (NaN/Inf) up to ~57 cycles at SHIFT_STEP=1. Backpressure: one op in flight; result held until out_ready.
module fsub_seq
    import fsub_seq_pkg::*;
#(
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res,
    output logic        ovf
);

    fsub_state_t  state;
    logic [31:0]  op_a, op_b;
    fp_unpacked_t lg;
    logic         sm_sign;
    logic [26:0]  sm_man;
    logic [7:0]   shift_rem;
    logic [27:0]  acc;
    logic [9:0]   exp_r;
    logic         sign_r;

    logic [31:0]  spec_res;

    fsub_seq_special u_special (
        .a   (op_a),
        .b   (op_b),
        .res (spec_res)
    );

    logic [31:0]  b_neg;
    logic         a_big, special_in;
    fp_unpacked_t ua, ub, lg_in, sm_in;
    logic [26:0]  sm_step;
    logic [7:0]   rem_step;
    logic [27:0]  sum;
    logic [27:0]  nrm;
    logic [9:0]   nexp;
    logic         norm_done;
    logic         inc;
    logic [24:0]  rman;
    logic [9:0]   rexp;

    always_comb begin
        b_neg      = {~b[31], b[30:0]};
        special_in = (a[30:23] == EXP_MAX) || (b[30:23] == EXP_MAX);
        a_big      = (a[30:0] >= b[30:0]);
        ua         = unpack_fp(a);
        ub         = unpack_fp(b_neg);
        lg_in      = a_big ? ua : ub;
        sm_in      = a_big ? ub : ua;

        // Alignment step: each lost bit folds into the sticky position.
        sm_step  = sm_man;
        rem_step = shift_rem;
        if (shift_rem >= 8'd27) begin
            sm_step  = {26'b0, |sm_man};
            rem_step = '0;
        end else begin
            for (int i = 0; i < SHIFT_STEP; i++) begin
                if (rem_step != 8'd0) begin
                    sm_step  = {1'b0, sm_step[26:2], sm_step[1] | sm_step[0]};
                    rem_step = rem_step - 8'd1;
                end
            end
        end

        if (lg.sign == sm_sign)
            sum = {1'b0, lg.man} + {1'b0, sm_man};
        else
            sum = {1'b0, lg.man} - {1'b0, sm_man};

        nrm  = acc;
        nexp = exp_r;
        if (acc[27]) begin
            nrm  = {1'b0, acc[27:2], acc[1] | acc[0]};
            nexp = exp_r + 10'd1;
        end else begin
            for (int i = 0; i < SHIFT_STEP; i++) begin
                if (!nrm[26] && nexp > 10'd1) begin
                    nrm  = {nrm[26:0], 1'b0};
                    nexp = nexp - 10'd1;
                end
            end
        end
        norm_done = nrm[26] || (nexp == 10'd1);

        // Hidden bit clear after rounding means the result stayed subnormal.
        inc  = acc[2] & (acc[1] | acc[0] | acc[3]);
        rman = {1'b0, acc[26:3]} + {24'b0, inc};
        if (rman[24])
            rexp = exp_r + 10'd1;
        else if (rman[23])
            rexp = exp_r;
        else
            rexp = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res       <= '0;
            ovf       <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            lg        <= '0;
            sm_sign   <= 1'b0;
            sm_man    <= '0;
            shift_rem <= '0;
            acc       <= '0;
            exp_r     <= '0;
            sign_r    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready  <= 1'b0;
                        op_a      <= a;
                        op_b      <= b_neg;
                        lg        <= lg_in;
                        sm_sign   <= sm_in.sign;
                        sm_man    <= sm_in.man;
                        shift_rem <= lg_in.exp - sm_in.exp;
                        state     <= special_in ? ST_SPECIAL : ST_ALIGN;
                    end
                end
                ST_SPECIAL: begin
                    res       <= spec_res;
                    ovf       <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_ALIGN: begin
                    if (shift_rem == 8'd0) begin
                        state <= ST_ADD;
                    end else begin
                        sm_man    <= sm_step;
                        shift_rem <= rem_step;
                        if (rem_step == 8'd0)
                            state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    if (sum == '0) begin
                        // Cancellation gives +0; only -0 - +0 keeps a negative sign.
                        res       <= {lg.sign & (lg.sign == sm_sign), 31'b0};
                        ovf       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        acc    <= sum;
                        exp_r  <= {2'b00, lg.exp};
                        sign_r <= lg.sign;
                        state  <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    acc   <= nrm;
                    exp_r <= nexp;
                    if (norm_done)
                        state <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (rexp >= 10'd255) begin
                        res <= {sign_r, EXP_MAX, 23'b0};
                        ovf <= 1'b1;
                    end else begin
                        res <= {sign_r, rexp[7:0], rman[22:0]};
                        ovf <= 1'b0;
                    end
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsub_seq.sv
// Directed bench for fsub_seq: vector table plus backpressure and mid-operation reset sequences.
module tb_fsub_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fsub_seq #(.SHIFT_STEP(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .ovf       (ovf)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
        end
    endtask

    task automatic add_vec(input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] vr, input logic vo);
        vec_t v;
        v.a = va; v.b = vb; v.res = vr; v.ovf = vo;
        vecs.push_back(v);
    endtask

    task automatic wait_ready(input string nm);
        int cyc = 0;
        while (!in_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!in_ready) chk({nm, "_in_ready_timeout"}, {31'b0, in_ready}, 32'd1);
    endtask

    task automatic wait_out(input string nm);
        int cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!out_valid) chk({nm, "_out_valid_timeout"}, {31'b0, out_valid}, 32'd1);
    endtask

    task automatic run_op(input string nm, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] vr, input logic vo);
        wait_ready(nm);
        a = va;
        b = vb;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({nm, "_busy"}, {31'b0, in_ready}, 32'd0);
        wait_out(nm);
        chk({nm, "_res"}, res, vr);
        chk({nm, "_ovf"}, {31'b0, ovf}, {31'b0, vo});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_res",       res,                32'd0);
        chk("rst_ovf",       {31'b0, ovf},       32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        add_vec(32'h40400000, 32'h3F800000, 32'h40000000, 1'b0); // 3 - 1
        add_vec(32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0); // 1 - 1 = +0
        add_vec(32'h3F800000, 32'h33000000, 32'h3F800000, 1'b0); // RNE tie rounds up to even
        add_vec(32'h00800000, 32'h00400000, 32'h00400000, 1'b0); // normal - subnormal
        add_vec(32'h00000001, 32'h00000001, 32'h00000000, 1'b0);
        add_vec(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1); // overflow
        add_vec(32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0); // Inf - Inf
        add_vec(32'h3F800000, 32'h40400000, 32'hC0000000, 1'b0); // 1 - 3
        add_vec(32'h3FC00000, 32'hC0200000, 32'h40800000, 1'b0); // 1.5 - (-2.5)
        add_vec(32'h40000000, 32'h3FC00000, 32'h3F000000, 1'b0); // 2 - 1.5
        add_vec(32'h00000000, 32'h00000000, 32'h00000000, 1'b0); // +0 - +0
        add_vec(32'h80000000, 32'h00000000, 32'h80000000, 1'b0); // -0 - +0
        add_vec(32'h3F800000, 32'h00000001, 32'h3F800000, 1'b0); // sticky-only collapse
        add_vec(32'h3F800000, 32'hB3800000, 32'h3F800000, 1'b0); // tie, LSB even: no inc
        add_vec(32'h3F800000, 32'hB4400000, 32'h3F800002, 1'b0); // tie, LSB odd: inc
        add_vec(32'h00C00000, 32'h00800000, 32'h00400000, 1'b0); // normal result goes subnormal
        add_vec(32'h7FC00001, 32'h3F800000, 32'h7FC00001, 1'b0); // a NaN
        add_vec(32'h3F800000, 32'h7F800001, 32'hFFC00001, 1'b0); // b NaN, sign flipped
        add_vec(32'h7FC00002, 32'hFFC00003, 32'h7FC00003, 1'b0); // both NaN, same eff sign
        add_vec(32'hFFC00002, 32'hFFC00003, 32'h7FC00003, 1'b0); // both NaN, diff eff sign
        add_vec(32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0); // Inf - 1
        add_vec(32'h3F800000, 32'h7F800000, 32'hFF800000, 1'b0); // 1 - Inf
        add_vec(32'h7F800000, 32'hFF800000, 32'h7F800000, 1'b0); // Inf - (-Inf)

        for (int i = 0; i < vecs.size(); i++)
            run_op($sformatf("v%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf);

        // Result must hold while the consumer stalls.
        wait_ready("bp");
        a = 32'h40400000;
        b = 32'h3F800000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out("bp");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_res_%0d", i), res, 32'h40000000);
            chk($sformatf("bp_in_ready_%0d", i), {31'b0, in_ready}, 32'd0);
            chk($sformatf("bp_out_valid_%0d", i), {31'b0, out_valid}, 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_release_in_ready",  {31'b0, in_ready},  32'd1);

        // Reset in the middle of a long alignment discards the operation.
        wait_ready("mid");
        a = 32'h4B000000;
        b = 32'h3F800000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_in_ready",  {31'b0, in_ready},  32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("mid_retry", 32'h4B000000, 32'h3F800000, 32'h4AFFFFFE, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
